pipeline_issue_ctrl: RTL and testbench
======================================

Name: pipeline_issue_ctrl

Overview:
Issue/hazard controller sitting between the decode stage and the execute stage of the 16-bit pipeline.
- Holds a per-register scoreboard of in-flight writebacks.
- Stalls decode when a source register (Rm/Rn/Rd, as flagged by the decoder's used mask) has a pending write.
- Sequences branch flushes for BL/BX/BLX.
- Only block that advances the decode→execute pipeline register.

Parameters:
NREG, 8, number of architectural registers (register number width = clog2(NREG) = 3)
CNT_W, 2, width of each scoreboard pending counter (max in-flight writes per register = 2**CNT_W-1)
BR_PENALTY, 2, cycles of flush after a branch issues (1..7)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
dec_valid  in  1  decode holds a valid instruction
num_Rm  in  3  decoded Rm number
num_Rn  in  3  decoded Rn number
num_Rd  in  3  decoded Rd number (STR/BX/BLX source)
used_RmRnRd  in  3  source-use mask {Rm,Rn,Rd}, bit2=Rm
write  in  1  instruction writes back
writenum  in  3  writeback register
inst_type  in  6  {RSV,BLX,BX,BL,STR,LDR} one-hot or zero
wb_valid  in  1  writeback stage retiring a write this cycle
wb_num  in  3  register retired
issue  out  1  instruction accepted into execute this cycle
stall  out  1  hold PC and decode register
flush  out  1  squash fetch/decode contents
busy  out  1  any scoreboard counter non-zero

Behaviour:
- Reset (async, rst_n=0): all counters 0, FSM=RUN, flush counter 0. Outputs: issue=0, stall=0, flush=0, busy=0.
- Hazard, combinational: src_hz = OR over i of used_RmRnRd[i] & (pend[reg_i] != 0), where reg = {num_Rm, num_Rn, num_Rd}.
- Saturation hazard: sat_hz = write & (pend[writenum] == max).
- FSM states RUN and FLUSH.
- RUN:
  - issue = dec_valid & ~src_hz & ~sat_hz.
  - stall = dec_valid & ~issue.
  - flush = 0.
  - If issue & inst_type[4:2] != 0: go to FLUSH with fcnt = BR_PENALTY.
- FLUSH:
  - issue = 0, stall = 0, flush = 1.
  - fcnt decrements each cycle; return to RUN in the cycle after fcnt reaches 1.
  - A branch issued at cycle t gives flush high for exactly cycles t+1 .. t+BR_PENALTY.
- Scoreboard update, registered:
  - pend[writenum] += (issue & write).
  - pend[wb_num] -= wb_valid.
  - Same register, same cycle: net unchanged.
  - wb_valid with pend[wb_num] == 0: ignored, counter stays 0 (no wrap). Simulation assertion fires.
  - Increments never exceed max, because sat_hz blocks them.
- Branch write (BL/BLX, write=1) is scoreboarded like any other write; its writeback may retire during FLUSH.
- RSV (inst_type[5]) and NOP issue normally with no scoreboard effect when write=0.
- wb_valid is honoured in every state, including FLUSH.
- busy = OR of all counters != 0; registered view, reflects state after the clock edge.
- rst_n asserted mid-flush or mid-stall: immediate return to reset state; in-flight writebacks are the caller's responsibility to squash.

Optional Feature:
HAZARD_WB_BYPASS_EN.
- Defined: a source whose only pending write retires this cycle is not a hazard. Condition: wb_valid & wb_num == reg & pend == 1. This requires the register file to forward wb data to decode reads.
- Undefined: such a source still stalls one more cycle until the counter is observed at 0.

Decomposition:
- Shared package pipeline_pkg:
  - inst_type bit index constants: IT_LDR=0, IT_STR=1, IT_BL=2, IT_BX=3, IT_BLX=4, IT_RSV=5.
  - used-mask bit indices: USE_RM=2, USE_RN=1, USE_RD=0.
  - FSM state enum: RUN, FLUSH.
- One sub-module: issue_scoreboard. Holds the NREG×CNT_W counters with inc/dec ports and a 3-port pending lookup. The FSM and issue logic stay in the top.

Test Plan:
- Write-then-read: ADD R2 (write=1, writenum=2) issues; next cycle MOV reading Rm=2 → stall=1 until wb_valid & wb_num=2; issue the cycle after (the same cycle with HAZARD_WB_BYPASS_EN).
- Independent registers: MOV R1 issued, then ADD with Rn=3, Rm=4 → issue=1 both cycles, stall never asserted.
- Branch flush: BL issues at cycle 10, BR_PENALTY=2 → flush=1 cycles 11–12, issue=0 there, issue possible at 13.
- Saturation: three LDR writing R5 back-to-back, no wb, CNT_W=2 → first three issue, fourth stalls; one wb on R5 → fourth issues next cycle.
- Simultaneous inc/dec: pend[3]=1; issue write R3 while wb_num=3 → pend[3] stays 1, busy=1.
- Async reset mid-FLUSH: rst_n low for half a cycle at fcnt=1 → flush, stall, busy drop to 0 immediately; all counters read 0 afterwards.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared constants and types for the 16-bit pipeline control blocks.
//   - inst_type one-hot bit indices (IT_*)
//   - decoder source-use mask bit indices (USE_*)
//   - issue controller FSM state enum
package pipeline_pkg;

    localparam int IT_LDR = 0;
    localparam int IT_STR = 1;
    localparam int IT_BL  = 2;
    localparam int IT_BX  = 3;
    localparam int IT_BLX = 4;
    localparam int IT_RSV = 5;

    localparam int USE_RM = 2;
    localparam int USE_RN = 1;
    localparam int USE_RD = 0;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } issue_state_e;

endpackage

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: per-register count of in-flight writebacks.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   inc_i / inc_num_i     add one pending write to a register
//   dec_i / dec_num_i     retire one pending write (ignored when count is 0)
//   rd_num_i / rd_cnt_o   three lookup ports (Rm, Rn, Rd order by USE_* index)
//   sat_num_i / sat_cnt_o lookup port for the destination register
//   busy_o                any counter non-zero (registered state)
module issue_scoreboard #(
    parameter int NREG  = 8,
    parameter int CNT_W = 2,
    parameter int RW    = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      inc_i,
    input  logic [RW-1:0]             inc_num_i,
    input  logic                      dec_i,
    input  logic [RW-1:0]             dec_num_i,
    input  logic [2:0][RW-1:0]        rd_num_i,
    output logic [2:0][CNT_W-1:0]     rd_cnt_o,
    input  logic [RW-1:0]             sat_num_i,
    output logic [CNT_W-1:0]          sat_cnt_o,
    output logic                      busy_o
);

    logic [NREG-1:0][CNT_W-1:0] pend_q, pend_d;
    logic [NREG-1:0]            inc_hit, dec_hit;

    for (genvar r = 0; r < NREG; r++) begin : g_cnt
        assign inc_hit[r] = inc_i && (inc_num_i == RW'(r));
        // A retire against an empty counter is dropped so the count never wraps.
        assign dec_hit[r] = dec_i && (dec_num_i == RW'(r)) && (pend_q[r] != '0);
        // Simultaneous inc and dec on the same register cancel out.
        assign pend_d[r]  = (inc_hit[r] && !dec_hit[r]) ? pend_q[r] + 1'b1 :
                            (dec_hit[r] && !inc_hit[r]) ? pend_q[r] - 1'b1 :
                                                          pend_q[r];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= '0;
        else        pend_q <= pend_d;
    end

    for (genvar p = 0; p < 3; p++) begin : g_rd
        assign rd_cnt_o[p] = pend_q[rd_num_i[p]];
    end

    assign sat_cnt_o = pend_q[sat_num_i];
    assign busy_o    = |pend_q;

    // A writeback with nothing outstanding means the pipeline lost track of a write.
    wb_underflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        dec_i |-> (pend_q[dec_num_i] != '0));

endmodule

// File: rtl/pipeline_issue_ctrl.sv
// pipeline_issue_ctrl: decode->execute issue and hazard controller.
// Stalls decode on pending writes to used sources or a saturated destination
// counter, and holds flush high for BR_PENALTY cycles after BL/BX/BLX issue.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   dec_valid                       decode holds a valid instruction
//   num_Rm/num_Rn/num_Rd, used_RmRnRd  source registers and use mask {Rm,Rn,Rd}
//   write, writenum                 instruction writes back to writenum
//   inst_type                       {RSV,BLX,BX,BL,STR,LDR}
//   wb_valid, wb_num                writeback retiring a write
//   issue, stall, flush, busy       control outputs
// Build option: define HAZARD_WB_BYPASS_EN to let a source whose last pending
// write retires this cycle issue without waiting (needs regfile wb forwarding).
module pipeline_issue_ctrl
    import pipeline_pkg::*;
#(
    parameter int NREG       = 8,
    parameter int CNT_W      = 2,
    parameter int BR_PENALTY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dec_valid,
    input  logic [2:0] num_Rm,
    input  logic [2:0] num_Rn,
    input  logic [2:0] num_Rd,
    input  logic [2:0] used_RmRnRd,
    input  logic       write,
    input  logic [2:0] writenum,
    input  logic [5:0] inst_type,
    input  logic       wb_valid,
    input  logic [2:0] wb_num,
    output logic       issue,
    output logic       stall,
    output logic       flush,
    output logic       busy
);

    localparam int RW     = 3;
    localparam int FCNT_W = 3;

    issue_state_e          state_q, state_d;
    logic [FCNT_W-1:0]     fcnt_q, fcnt_d;

    logic [2:0][RW-1:0]    src_num;
    logic [2:0][CNT_W-1:0] src_cnt;
    logic [CNT_W-1:0]      sat_cnt;
    logic [2:0]            src_byp, src_hz_v;
    logic                  src_hz, sat_hz, issue_run, branch;

    // Flag-only inst_type bits; they have no effect on issue or the scoreboard.
    logic unused_it;
    assign unused_it = ^{inst_type[IT_RSV], inst_type[IT_STR], inst_type[IT_LDR]};

    assign src_num[USE_RM] = num_Rm;
    assign src_num[USE_RN] = num_Rn;
    assign src_num[USE_RD] = num_Rd;

    issue_scoreboard #(
        .NREG  (NREG),
        .CNT_W (CNT_W),
        .RW    (RW)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_i     (issue & write),
        .inc_num_i (writenum),
        .dec_i     (wb_valid),
        .dec_num_i (wb_num),
        .rd_num_i  (src_num),
        .rd_cnt_o  (src_cnt),
        .sat_num_i (writenum),
        .sat_cnt_o (sat_cnt),
        .busy_o    (busy)
    );

    for (genvar p = 0; p < 3; p++) begin : g_hz
`ifdef HAZARD_WB_BYPASS_EN
        assign src_byp[p] = wb_valid && (wb_num == src_num[p]) && (src_cnt[p] == CNT_W'(1));
`else
        assign src_byp[p] = 1'b0;
`endif
        assign src_hz_v[p] = used_RmRnRd[p] && (src_cnt[p] != '0) && !src_byp[p];
    end

    assign src_hz    = |src_hz_v;
    // Another write to a full counter would overflow it, so hold the instruction.
    assign sat_hz    = write && (sat_cnt == '1);
    assign issue_run = dec_valid && !src_hz && !sat_hz;
    assign branch    = |inst_type[IT_BLX:IT_BL];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            RUN: begin
                if (issue_run && branch) begin
                    state_d = FLUSH;
                    fcnt_d  = FCNT_W'(BR_PENALTY);
                end
            end
            FLUSH: begin
                // fcnt counts remaining flush cycles including the current one.
                if (fcnt_q == FCNT_W'(1)) begin
                    state_d = RUN;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d  = fcnt_q - 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                fcnt_d  = '0;
            end
        endcase
    end

    always_comb begin
        issue = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        case (state_q)
            RUN: begin
                issue = issue_run;
                stall = dec_valid && !issue_run;
            end
            FLUSH: flush = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pipeline_issue_ctrl.sv
module tb_pipeline_issue_ctrl;

    localparam int BRP  = 2;
    localparam int MAXC = 3;
`ifdef HAZARD_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dec_valid;
    logic [2:0] num_Rm, num_Rn, num_Rd, used_RmRnRd, writenum, wb_num;
    logic       write, wb_valid;
    logic [5:0] inst_type;
    logic       issue, stall, flush, busy;

    int checks = 0;
    int errors = 0;

    // Reference model: pending-write count per register and flush cycles left.
    int pend[8];
    int flush_left;

    pipeline_issue_ctrl #(.NREG(8), .CNT_W(2), .BR_PENALTY(BRP)) dut (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid),
        .num_Rm(num_Rm), .num_Rn(num_Rn), .num_Rd(num_Rd), .used_RmRnRd(used_RmRnRd),
        .write(write), .writenum(writenum), .inst_type(inst_type),
        .wb_valid(wb_valid), .wb_num(wb_num),
        .issue(issue), .stall(stall), .flush(flush), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (pend[i]) pend[i] = 0;
        flush_left = 0;
    endtask

    task automatic drive(input logic dv, input logic [2:0] rm, input logic [2:0] rn,
                         input logic [2:0] rd, input logic [2:0] used, input logic wr,
                         input logic [2:0] wn, input logic [5:0] it,
                         input logic wbv, input logic [2:0] wbn);
        dec_valid = dv; num_Rm = rm; num_Rn = rn; num_Rd = rd; used_RmRnRd = used;
        write = wr; writenum = wn; inst_type = it; wb_valid = wbv; wb_num = wbn;
    endtask

    // Called 1 time unit after a rising edge: check outputs against the model,
    // cross the next edge, advance the model, and return 1 unit after that edge.
    task automatic step(input string tag);
        int  src[3];
        bit  hz, sat, ei, es, ef, eb, dec_ok;
        #2;
        src[2] = int'(num_Rm); src[1] = int'(num_Rn); src[0] = int'(num_Rd);
        hz = 0;
        for (int i = 0; i < 3; i++)
            if (used_RmRnRd[i] && pend[src[i]] > 0 &&
                !(BYP && wb_valid && int'(wb_num) == src[i] && pend[src[i]] == 1))
                hz = 1;
        sat = write && pend[writenum] == MAXC;
        ef  = flush_left > 0;
        ei  = !ef && dec_valid && !hz && !sat;
        es  = !ef && dec_valid && !ei;
        eb  = 0;
        foreach (pend[i]) if (pend[i] > 0) eb = 1;
        chk({tag, ".issue"}, 8'(issue), 8'(ei));
        chk({tag, ".stall"}, 8'(stall), 8'(es));
        chk({tag, ".flush"}, 8'(flush), 8'(ef));
        chk({tag, ".busy"},  8'(busy),  8'(eb));
        dec_ok = wb_valid && pend[wb_num] > 0;
        @(posedge clk);
        if (ei && write) pend[writenum]++;
        if (dec_ok) pend[wb_num]--;
        if (ef) flush_left--;
        else if (ei && inst_type[4:2] != 3'b000) flush_left = BRP;
        #1;
    endtask

    task automatic idle_wb(output logic wbv, output logic [2:0] wbn);
        int q[$];
        foreach (pend[i]) if (pend[i] > 0) q.push_back(i);
        wbv = 1'b0; wbn = 3'd0;
        if (q.size() > 0) begin
            wbv = 1'b1;
            wbn = 3'(q[$urandom_range(0, q.size() - 1)]);
        end
    endtask

    task automatic drain(input string tag);
        logic       wbv;
        logic [2:0] wbn;
        for (int n = 0; n < 40; n++) begin
            idle_wb(wbv, wbn);
            if (!wbv && flush_left == 0) break;
            drive(0, 0, 0, 0, 0, 0, 0, 0, wbv, wbn);
            step(tag);
        end
    endtask

    initial begin
        logic       wbv;
        logic [2:0] wbn;
        logic [5:0] it;
        int         r;

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        chk("rst.issue", 8'(issue), 8'd0);
        chk("rst.stall", 8'(stall), 8'd0);
        chk("rst.flush", 8'(flush), 8'd0);
        chk("rst.busy",  8'(busy),  8'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Write-then-read on R2
        drive(1, 0, 0, 0, 3'b000, 1, 3'd2, 0, 0, 0); step("wr.add");
        drive(1, 3'd2, 0, 0, 3'b100, 1, 3'd1, 0, 0, 0);
        #1 chk("wr.stall_const", 8'(stall), 8'd1); step("wr.mov0");
        drive(1, 3'd2, 0, 0, 3'b100, 1, 3'd1, 0, 0, 0); step("wr.mov1");
        drive(1, 3'd2, 0, 0, 3'b100, 1, 3'd1, 0, 1, 3'd2);
        #1 chk("wr.wbcycle_issue", 8'(issue), 8'(BYP)); step("wr.wb");
        if (!BYP) begin
            drive(1, 3'd2, 0, 0, 3'b100, 1, 3'd1, 0, 0, 0);
            #1 chk("wr.after_issue", 8'(issue), 8'd1); step("wr.after");
        end
        drain("wr.drain");

        // Independent registers
        drive(1, 0, 0, 0, 3'b000, 1, 3'd1, 0, 0, 0);
        #1 chk("ind.mov", 8'(issue), 8'd1); step("ind.mov");
        drive(1, 3'd4, 3'd3, 0, 3'b110, 1, 3'd6, 0, 0, 0);
        #1 chk("ind.add", 8'(issue), 8'd1); step("ind.add");
        drain("ind.drain");

        // Branch flush: BL writes R7 (link), retire it inside the flush window
        drive(1, 0, 0, 0, 3'b000, 1, 3'd7, 6'b000100, 0, 0); step("br.bl");
        drive(1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
        #1 chk("br.flush1", 8'(flush), 8'd1); step("br.f1");
        drive(1, 0, 0, 0, 3'b000, 0, 0, 0, 1, 3'd7);
        #1 chk("br.flush2_issue", 8'(issue), 8'd0); step("br.f2");
        drive(1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
        #1 chk("br.resume", 8'(issue), 8'd1); step("br.resume");

        // Saturation on R5
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 3'b000, 1, 3'd5, 6'b000001, 0, 0); step("sat.ldr");
        end
        drive(1, 0, 0, 0, 3'b000, 1, 3'd5, 6'b000001, 0, 0);
        #1 chk("sat.stall4", 8'(stall), 8'd1); step("sat.ldr4");
        drive(1, 0, 0, 0, 3'b000, 1, 3'd5, 6'b000001, 1, 3'd5); step("sat.wb");
        drive(1, 0, 0, 0, 3'b000, 1, 3'd5, 6'b000001, 0, 0);
        #1 chk("sat.issue4", 8'(issue), 8'd1); step("sat.ldr4b");
        drain("sat.drain");

        // Simultaneous inc/dec on R3
        drive(1, 0, 0, 0, 3'b000, 1, 3'd3, 0, 0, 0); step("sim.w1");
        drive(1, 0, 0, 0, 3'b000, 1, 3'd3, 0, 1, 3'd3); step("sim.incdec");
        drive(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
        #1 chk("sim.busy", 8'(busy), 8'd1); step("sim.hold");
        drive(0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 3'd3); step("sim.wb");
        chk("sim.empty", 8'(busy), 8'd0);

        // Async reset mid-flush with a write still pending
        drive(1, 0, 0, 0, 3'b000, 1, 3'd6, 0, 0, 0); step("ar.w6");
        drive(1, 0, 0, 3'd0, 3'b001, 0, 0, 6'b001000, 0, 0); step("ar.bx");
        drive(1, 3'd6, 0, 0, 3'b100, 0, 0, 0, 0, 0); step("ar.f1");
        #2;
        rst_n = 1'b0; dec_valid = 1'b0;
        #1;
        chk("ar.flush", 8'(flush), 8'd0);
        chk("ar.stall", 8'(stall), 8'd0);
        chk("ar.busy",  8'(busy),  8'd0);
        chk("ar.issue", 8'(issue), 8'd0);
        model_reset();
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1, 3'd6, 3'd6, 3'd6, 3'b111, 0, 0, 0, 0, 0);
        #1 chk("ar.r6_free", 8'(issue), 8'd1); step("ar.after");

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 15);
            if (r < 3)       it = 6'(1 << (2 + r));
            else if (r == 3) it = 6'b100000;
            else if (r < 6)  it = 6'(1 << (r - 4));
            else             it = 6'b000000;
            idle_wb(wbv, wbn);
            if ($urandom_range(0, 1) == 0) wbv = 1'b0;
            drive($urandom_range(0, 3) != 0, 3'($urandom), 3'($urandom), 3'($urandom),
                  3'($urandom), 1'($urandom), 3'($urandom), it, wbv, wbn);
            step("rnd");
        end
        drain("rnd.drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
